dds_phase_apply: RTL and testbench
==================================

DDS_PHASE_APPLY -- requirements
Module: dds_phase_apply

Interface
REQ-001 SHALL have parameter SIZE_ACC, default 16: phase accumulator width in bits.
REQ-002 SHALL have parameter SIZE_PHASE, default 8: output address and offset width in bits, with SIZE_PHASE <= SIZE_ACC.
REQ-003 SHALL have parameter SIZE_TO, default 10: wrap-timeout counter width in bits.
REQ-004 SHALL have port i_clk, input, 1: sole clock, all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port i_tick, input, 1: sample strobe, one accumulator step per high cycle.
REQ-007 SHALL have port i_fcw, input, SIZE_ACC: unsigned frequency control word.
REQ-008 SHALL have port i_phase_valid, input, 1: new phase offset offered.
REQ-009 SHALL have port i_phase, input, SIZE_PHASE: requested offset, unsigned, taken modulo 2^SIZE_PHASE.
REQ-010 SHALL have port o_phase_ready, output, 1: offset accepted on cycles where valid and ready are both high.
REQ-011 SHALL have port o_addr_ref, output, SIZE_PHASE: reference-channel wave ROM address.
REQ-012 SHALL have port o_addr_shift, output, SIZE_PHASE: phase-shifted-channel wave ROM address.
REQ-013 SHALL have port o_sample_valid, output, 1: one-cycle pulse marking new addresses.
REQ-014 SHALL have port o_busy, output, 1: an accepted offset is pending and not yet applied.

Function
REQ-015 SHALL add i_fcw to acc, modulo 2^SIZE_ACC, on each cycle i_tick=1; acc SHALL hold otherwise.
REQ-016 SHALL define wrap as the carry-out of that addition.
REQ-017 SHALL register o_addr_ref = new acc[SIZE_ACC-1 -: SIZE_PHASE] on the edge where i_tick=1, for a latency of 1 cycle.
REQ-018 SHALL register o_addr_shift = (new addr_ref + applied offset) mod 2^SIZE_PHASE on that same edge.
REQ-019 SHALL assert o_sample_valid exactly in the cycle after each i_tick cycle.
REQ-020 SHALL use a two-state FSM: IDLE and WAIT_WRAP.
REQ-021 In IDLE: o_phase_ready=1, o_busy=0; on i_phase_valid, i_phase SHALL be captured into pending, the timeout counter cleared, and the FSM SHALL go to WAIT_WRAP.
REQ-022 In WAIT_WRAP: o_phase_ready=0, o_busy=1; i_phase_valid SHALL be ignored (no acceptance, no queueing).
REQ-023 In WAIT_WRAP on a tick with wrap=1: applied := pending, taking effect in the o_addr_shift computed at that same tick; the FSM SHALL return to IDLE.
REQ-024 In WAIT_WRAP on a tick with wrap=0: the timeout counter SHALL increment.
REQ-025 When the counter reaches 2^SIZE_TO-1 on a tick: apply as in REQ-023 and return to IDLE, so that i_fcw=0 never deadlocks.
REQ-026 Acceptance and wrap in the same IDLE cycle: accept the offset; the current wrap SHALL NOT apply it; only the next wrap or timeout applies it.
REQ-027 Accepting an offset equal to the applied offset SHALL still run a full WAIT_WRAP cycle.
REQ-028 A change of i_fcw SHALL affect only the next tick; acc SHALL never be cleared by an fcw change.

Reset
REQ-029 While i_rst=1: acc=0, applied=0, pending=0, timeout counter=0, FSM=IDLE.
REQ-030 While i_rst=1: o_addr_ref=0, o_addr_shift=0, o_sample_valid=0, o_busy=0, o_phase_ready=1.
REQ-031 Reset mid-WAIT_WRAP SHALL discard the pending offset; no apply after release.

Structure
REQ-032 Package dds_phase_pkg SHALL hold the FSM state enum (IDLE, WAIT_WRAP) and default width constants.
REQ-033 Sub-module dds_phase_acc SHALL be the only one: accumulator plus wrap flag; FSM, offset and output registers stay in the top.

Verification (SIZE_ACC=16, SIZE_PHASE=8, SIZE_TO=4)
REQ-034 i_fcw=0x0100, tick every cycle, no offset -> o_addr_ref 1,2,3,... with o_addr_shift equal, o_sample_valid each cycle after tick.
REQ-035 From acc=0, fcw=0x4000, offer i_phase=0x40 -> ready drops, busy=1 for ticks 1-3; at 4th tick (wrap) o_addr_ref=0x00 and o_addr_shift=0x40; busy=0.
REQ-036 Offer 0x80, then offer 0x20 while busy -> 0x20 not accepted (ready=0); only 0x80 applied at wrap.
REQ-037 fcw=0, offer 0x10 -> applied on 15th tick via timeout, o_addr_shift=0x10, FSM IDLE.
REQ-038 Acceptance coincident with a wrap (acc=0xC000, fcw=0x4000) -> o_addr_shift unchanged at that tick, offset applied at next wrap.
REQ-039 Assert i_rst during WAIT_WRAP -> all outputs at reset values; after release, wraps do not apply the old pending offset.

Source files
------------

// File: rtl/dds_phase_pkg.sv
// rtl/dds_phase_pkg.sv - shared state type and default widths for the dds phase-offset block
package dds_phase_pkg;

  localparam int DEF_SIZE_ACC   = 16;
  localparam int DEF_SIZE_PHASE = 8;
  localparam int DEF_SIZE_TO    = 10;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_WRAP = 1'b1
  } phase_state_t;

endpackage

// File: rtl/dds_phase_acc.sv
// rtl/dds_phase_acc.sv - phase accumulator with carry-out wrap flag and next-address slice
module dds_phase_acc #(
  parameter int SIZE_ACC   = 16,
  parameter int SIZE_PHASE = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_tick,
  input  logic [SIZE_ACC-1:0]   i_fcw,
  output logic [SIZE_PHASE-1:0] o_addr_next,
  output logic                  o_wrap
);

  logic [SIZE_ACC-1:0] acc;
  logic [SIZE_ACC:0]   acc_sum;

  // Sum with one extra bit so the carry-out doubles as the wrap flag.
  always_comb begin
    acc_sum     = {1'b0, acc} + {1'b0, i_fcw};
    o_wrap      = acc_sum[SIZE_ACC];
    o_addr_next = acc_sum[SIZE_ACC-1 -: SIZE_PHASE];
  end

  // Advance only on ticks; an fcw change just alters the next step size.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc <= '0;
    end else if (i_tick) begin
      acc <= acc_sum[SIZE_ACC-1:0];
    end
  end

endmodule

// File: rtl/dds_phase_apply.sv
// rtl/dds_phase_apply.sv - DDS address generator applying phase offsets only at accumulator wrap
module dds_phase_apply
  import dds_phase_pkg::*;
#(
  parameter int SIZE_ACC   = DEF_SIZE_ACC,
  parameter int SIZE_PHASE = DEF_SIZE_PHASE,
  parameter int SIZE_TO    = DEF_SIZE_TO
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_tick,
  input  logic [SIZE_ACC-1:0]   i_fcw,
  input  logic                  i_phase_valid,
  input  logic [SIZE_PHASE-1:0] i_phase,
  output logic                  o_phase_ready,
  output logic [SIZE_PHASE-1:0] o_addr_ref,
  output logic [SIZE_PHASE-1:0] o_addr_shift,
  output logic                  o_sample_valid,
  output logic                  o_busy
);

  // Counter value on the tick before it would read all-ones; that tick forces the apply.
  localparam logic [SIZE_TO-1:0] TO_LAST = {SIZE_TO{1'b1}} - 1'b1;

  phase_state_t          state, state_next;
  logic [SIZE_PHASE-1:0] pending;
  logic [SIZE_PHASE-1:0] applied;
  logic [SIZE_PHASE-1:0] eff_offset;
  logic [SIZE_TO-1:0]    to_cnt;
  logic [SIZE_PHASE-1:0] addr_next;
  logic                  wrap;
  logic                  accept;
  logic                  apply_now;

  dds_phase_acc #(
    .SIZE_ACC   (SIZE_ACC),
    .SIZE_PHASE (SIZE_PHASE)
  ) u_acc (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_tick      (i_tick),
    .i_fcw       (i_fcw),
    .o_addr_next (addr_next),
    .o_wrap      (wrap)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake and apply decisions; a wrap seen while still IDLE never applies.
  always_comb begin
    state_next    = state;
    o_phase_ready = 1'b0;
    o_busy        = 1'b0;
    accept        = 1'b0;
    apply_now     = 1'b0;
    case (state)
      IDLE: begin
        o_phase_ready = 1'b1;
        accept        = i_phase_valid;
        if (i_phase_valid) begin
          state_next = WAIT_WRAP;
        end
      end
      WAIT_WRAP: begin
        o_busy    = 1'b1;
        apply_now = i_tick && (wrap || (to_cnt == TO_LAST));
        if (apply_now) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    eff_offset = apply_now ? pending : applied;
  end

  // Offset capture, apply and timeout counting.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending <= '0;
      applied <= '0;
      to_cnt  <= '0;
    end else begin
      if (accept) begin
        pending <= i_phase;
        to_cnt  <= '0;
      end else if (state == WAIT_WRAP && i_tick && !wrap) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (apply_now) begin
        applied <= pending;
      end
    end
  end

  // Output addresses update one cycle after each tick, shift channel uses the offset in force.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_addr_ref     <= '0;
      o_addr_shift   <= '0;
      o_sample_valid <= 1'b0;
    end else begin
      o_sample_valid <= i_tick;
      if (i_tick) begin
        o_addr_ref   <= addr_next;
        o_addr_shift <= addr_next + eff_offset;
      end
    end
  end

endmodule

// File: tb/tb_dds_phase_apply.sv
// tb/tb_dds_phase_apply.sv - directed self-checking bench for dds_phase_apply
module tb_dds_phase_apply;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_tick = 1'b0;
  logic [15:0] i_fcw = '0;
  logic        i_phase_valid = 1'b0;
  logic [7:0]  i_phase = '0;
  logic        o_phase_ready;
  logic [7:0]  o_addr_ref;
  logic [7:0]  o_addr_shift;
  logic        o_sample_valid;
  logic        o_busy;

  int n_cmp = 0;
  int n_bad = 0;

  dds_phase_apply #(
    .SIZE_ACC   (16),
    .SIZE_PHASE (8),
    .SIZE_TO    (4)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_tick         (i_tick),
    .i_fcw          (i_fcw),
    .i_phase_valid  (i_phase_valid),
    .i_phase        (i_phase),
    .o_phase_ready  (o_phase_ready),
    .o_addr_ref     (o_addr_ref),
    .o_addr_shift   (o_addr_shift),
    .o_sample_valid (o_sample_valid),
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1ns later, then idle inputs.
  task automatic cyc(input logic tick, input logic pv, input logic [7:0] ph);
    i_tick        = tick;
    i_phase_valid = pv;
    i_phase       = ph;
    @(posedge i_clk);
    #1;
    i_tick        = 1'b0;
    i_phase_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [7:0] ref_e, input logic [7:0] sh_e,
                           input logic sv_e, input logic busy_e);
    check({tag, ".ref"},   {24'd0, o_addr_ref},   {24'd0, ref_e});
    check({tag, ".shift"}, {24'd0, o_addr_shift}, {24'd0, sh_e});
    check({tag, ".valid"}, {31'd0, o_sample_valid}, {31'd0, sv_e});
    check({tag, ".busy"},  {31'd0, o_busy},       {31'd0, busy_e});
    check({tag, ".ready"}, {31'd0, o_phase_ready}, {31'd0, !busy_e});
  endtask

  task automatic do_reset();
    #2;
    i_rst = 1'b1;
    #1;
    check_out("rst", 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge i_clk);
    #3;
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    // Reset values while reset is held
    #3;
    check_out("por", 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge i_clk);
    #3;
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // Plain stepping, no offset
    i_fcw = 16'h0100;
    cyc(1, 0, 8'h00); check_out("a1", 8'h01, 8'h01, 1'b1, 1'b0);
    cyc(1, 0, 8'h00); check_out("a2", 8'h02, 8'h02, 1'b1, 1'b0);
    cyc(1, 0, 8'h00); check_out("a3", 8'h03, 8'h03, 1'b1, 1'b0);
    cyc(0, 0, 8'h00); check_out("a_hold", 8'h03, 8'h03, 1'b0, 1'b0);

    // Offset 0x40 applied at first wrap
    do_reset();
    i_fcw = 16'h4000;
    cyc(0, 1, 8'h40); check_out("b_acc", 8'h00, 8'h00, 1'b0, 1'b1);
    cyc(1, 0, 8'h00); check_out("b1", 8'h40, 8'h40, 1'b1, 1'b1);
    cyc(1, 0, 8'h00); check_out("b2", 8'h80, 8'h80, 1'b1, 1'b1);
    cyc(1, 0, 8'h00); check_out("b3", 8'hC0, 8'hC0, 1'b1, 1'b1);
    cyc(1, 0, 8'h00); check_out("b4_wrap", 8'h00, 8'h40, 1'b1, 1'b0);

    // Offer 0x80, then 0x20 while busy: only 0x80 lands
    cyc(0, 1, 8'h80); check_out("c_acc", 8'h00, 8'h40, 1'b0, 1'b1);
    check("c_ready_busy", {31'd0, o_phase_ready}, 32'd0);
    cyc(1, 1, 8'h20); check_out("c1", 8'h40, 8'h80, 1'b1, 1'b1);
    cyc(1, 0, 8'h00); check_out("c2", 8'h80, 8'hC0, 1'b1, 1'b1);
    cyc(1, 0, 8'h00); check_out("c3", 8'hC0, 8'h00, 1'b1, 1'b1);
    cyc(1, 0, 8'h00); check_out("c4_wrap", 8'h00, 8'h80, 1'b1, 1'b0);
    cyc(1, 0, 8'h00); check_out("c5", 8'h40, 8'hC0, 1'b1, 1'b0);

    // fcw=0: timeout applies on the 15th tick
    do_reset();
    i_fcw = 16'h0000;
    cyc(0, 1, 8'h10); check_out("d_acc", 8'h00, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 13; i++) cyc(1, 0, 8'h00);
    cyc(1, 0, 8'h00); check_out("d14", 8'h00, 8'h00, 1'b1, 1'b1);
    cyc(1, 0, 8'h00); check_out("d15_to", 8'h00, 8'h10, 1'b1, 1'b0);

    // Acceptance on the same tick as a wrap does not apply there
    do_reset();
    i_fcw = 16'h4000;
    cyc(1, 0, 8'h00);
    cyc(1, 0, 8'h00);
    cyc(1, 0, 8'h00); check_out("e_pre", 8'hC0, 8'hC0, 1'b1, 1'b0);
    cyc(1, 1, 8'h30); check_out("e_coinc", 8'h00, 8'h00, 1'b1, 1'b1);
    cyc(1, 0, 8'h00); check_out("e1", 8'h40, 8'h40, 1'b1, 1'b1);
    cyc(1, 0, 8'h00); check_out("e2", 8'h80, 8'h80, 1'b1, 1'b1);
    cyc(1, 0, 8'h00); check_out("e3", 8'hC0, 8'hC0, 1'b1, 1'b1);
    cyc(1, 0, 8'h00); check_out("e4_wrap", 8'h00, 8'h30, 1'b1, 1'b0);

    // Reset mid-wait discards the pending offset
    do_reset();
    cyc(0, 1, 8'h70);
    cyc(1, 0, 8'h00); check_out("f1", 8'h40, 8'h40, 1'b1, 1'b1);
    do_reset();
    cyc(1, 0, 8'h00);
    cyc(1, 0, 8'h00);
    cyc(1, 0, 8'h00);
    cyc(1, 0, 8'h00); check_out("f_wrap", 8'h00, 8'h00, 1'b1, 1'b0);
    cyc(1, 0, 8'h00); check_out("f_after", 8'h40, 8'h40, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
